// File: rtl/txpll_dri_pkg.sv
// txpll_dri_pkg: shared encodings, FSM states and DRI field layout for the TX_PLL DRI master.
package txpll_dri_pkg;
  typedef enum logic [1:0] {CMD_RD = 2'b00, CMD_WR = 2'b01, CMD_RMW = 2'b10, CMD_RSV = 2'b11} cmd_op_e;
  localparam logic [1:0] DRI_OP_IDLE = 2'b00;
  localparam logic [1:0] DRI_OP_RD   = 2'b01;
  localparam logic [1:0] DRI_OP_WR   = 2'b10;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP, GAP} state_e;
  localparam int OP_LSB   = 9;
  localparam int ADDR_LSB = 0;
  localparam int ACK_BIT  = 32;
  function automatic logic [31:0] rmw_merge(input logic [31:0] rd, input logic [31:0] wd, input logic [31:0] mask);
    return (rd & ~mask) | (wd & mask);
  endfunction
endpackage

// File: rtl/dri_timeout_ctr.sv
// dri_timeout_ctr: clearable up-counter; term is high in the limit-th cycle after the last clear.
module dri_timeout_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         term
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= clr ? '0 : cnt + 1'b1;
  assign term = cnt == limit - 1'b1;
endmodule

// File: rtl/txpll_dri_master.sv
// txpll_dri_master: fabric-side DRI initiator for TX_PLL doing read, write and read-modify-write accesses.
module txpll_dri_master
  import txpll_dri_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 255,
  parameter int CMD_GAP     = 2
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [31:0]       cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [10:0]       dri_ctrl,
  output logic [32:0]       dri_wdata,
  input  logic [32:0]       dri_rdata,
  input  logic              dri_interrupt,
  output logic              irq_pending,
  input  logic              irq_clr,
  output logic              busy
);
  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_CYC);
  localparam logic [15:0] GAP_LIM = 16'(CMD_GAP);
  state_e            state, state_nx;
  cmd_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, mask_q;
  logic              live, term, ack;
  assign ack = dri_rdata[ACK_BIT];
  // one counter serves both the ack timeout and the inter-command gap
  dri_timeout_ctr #(.W(16)) u_ctr (
    .clk  (CLK),
    .clr  (!RESETN || !(state inside {RD_WAIT, WR_WAIT, GAP})),
    .limit(state == GAP ? GAP_LIM : TO_LIM),
    .term (term)
  );
  always_ff @(posedge CLK)
    state <= RESETN ? state_nx : IDLE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (cmd_ready && cmd_valid)
                  state_nx = cmd_op == CMD_RSV ? RESP : cmd_op == CMD_WR ? WR_ISSUE : RD_ISSUE;
      RD_ISSUE: state_nx = RD_WAIT;
      WR_ISSUE: state_nx = WR_WAIT;
      RD_WAIT:  state_nx = ack ? (op_q == CMD_RMW ? WR_ISSUE : RESP) : term ? RESP : RD_WAIT;
      WR_WAIT:  state_nx = ack || term ? RESP : WR_WAIT;
      RESP:     state_nx = rsp_ready ? (CMD_GAP == 0 ? IDLE : GAP) : RESP;
      GAP:      state_nx = term ? IDLE : GAP;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = live && state == IDLE;
    rsp_valid = state == RESP;
    busy      = state != IDLE;
    dri_ctrl  = '0;
    dri_ctrl[OP_LSB +: 2] = state == RD_ISSUE ? DRI_OP_RD : state == WR_ISSUE ? DRI_OP_WR : DRI_OP_IDLE;
    if (state inside {RD_ISSUE, WR_ISSUE}) dri_ctrl[ADDR_LSB +: ADDR_W] = addr_q;
    dri_wdata = state == WR_ISSUE ? {1'b0, wdata_q} : '0;
  end
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      live        <= 1'b0;
      irq_pending <= 1'b0;
      op_q        <= CMD_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      live        <= 1'b1;
      irq_pending <= dri_interrupt || (irq_pending && !irq_clr);
      if (cmd_ready && cmd_valid) begin
        op_q      <= cmd_op_e'(cmd_op);
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        mask_q    <= cmd_mask;
        rsp_rdata <= '0;
        rsp_err   <= cmd_op == CMD_RSV;
      end
      // a read ack wins over a simultaneous timeout; wdata_q only matters afterwards for RMW
      if (state == RD_WAIT && ack) begin
        rsp_rdata <= dri_rdata[31:0];
        wdata_q   <= rmw_merge(dri_rdata[31:0], wdata_q, mask_q);
      end else if (state inside {RD_WAIT, WR_WAIT} && !ack && term)
        rsp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_txpll_dri_master.sv
// tb_txpll_dri_master: directed self-checking bench for txpll_dri_master (TIMEOUT_CYC=8, CMD_GAP=2).
module tb_txpll_dri_master;
  logic        CLK = 1'b0;
  logic        RESETN, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic        dri_interrupt, irq_pending, irq_clr, busy;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata, cmd_mask, rsp_rdata;
  logic [10:0] dri_ctrl;
  logic [32:0] dri_wdata, dri_rdata;
  int checks = 0, failures = 0;
  logic saw_wr;

  txpll_dri_master #(.ADDR_W(9), .TIMEOUT_CYC(8), .CMD_GAP(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dri_ctrl(dri_ctrl),
    .dri_wdata(dri_wdata), .dri_rdata(dri_rdata), .dri_interrupt(dri_interrupt),
    .irq_pending(irq_pending), .irq_clr(irq_clr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_dri_ctrl"}, 64'(dri_ctrl), 64'd0);
    chk({tag, "_dri_wdata"}, 64'(dri_wdata), 64'd0);
    chk({tag, "_irq"}, 64'(irq_pending), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [8:0] addr, input logic [31:0] wd, input logic [31:0] mask);
    chk("issue_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_mask  = mask;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({tag, "_gap0"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    tick;
    chk({tag, "_gap1"}, 64'(cmd_ready), 64'd0);
    tick;
    chk({tag, "_idle"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    RESETN = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
    rsp_ready = 1'b0; dri_rdata = '0; dri_interrupt = 1'b0; irq_clr = 1'b0;
    tick;
    tick;
    chk_reset("por");
    RESETN = 1'b1;
    tick;
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
    // stray ack in IDLE must be ignored
    dri_rdata = {1'b1, 32'h7777_7777};
    tick;
    dri_rdata = '0;
    chk("stray_ack_valid", 64'(rsp_valid), 64'd0);
    chk("stray_ack_busy", 64'(busy), 64'd0);
    // read 0x012, ack 3 cycles after strobe
    issue(2'b00, 9'h012, 32'h0, 32'h0);
    chk("rd_strobe", 64'(dri_ctrl), 64'h212);
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_ready_low", 64'(cmd_ready), 64'd0);
    tick;
    chk("rd_strobe_off", 64'(dri_ctrl), 64'h0);
    tick;
    tick;
    dri_rdata = {1'b1, 32'hA5A5_0001};
    chk("rd_no_early_rsp", 64'(rsp_valid), 64'd0);
    tick;
    dri_rdata = '0;
    chk("rd_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
    chk("rd_err", 64'(rsp_err), 64'd0);
    handshake("rd");
    // write 0x040
    issue(2'b01, 9'h040, 32'hDEAD_BEEF, 32'h0);
    chk("wr_strobe", 64'(dri_ctrl), 64'h440);
    chk("wr_wdata", 64'(dri_wdata), 64'h0_DEAD_BEEF);
    tick;
    chk("wr_strobe_off", 64'(dri_ctrl), 64'h0);
    chk("wr_wdata_off", 64'(dri_wdata), 64'h0);
    dri_rdata = {1'b1, 32'h1234_5678};
    tick;
    dri_rdata = '0;
    chk("wr_rdata_zero", 64'(rsp_rdata), 64'h0);
    chk("wr_err", 64'(rsp_err), 64'd0);
    handshake("wr");
    // RMW 0x003: best-case read ack, merged write
    issue(2'b10, 9'h003, 32'h0000_00FF, 32'h0000_0F0F);
    chk("rmw_rd_strobe", 64'(dri_ctrl), 64'h203);
    tick;
    dri_rdata = {1'b1, 32'hFFFF_0000};
    tick;
    dri_rdata = '0;
    chk("rmw_wr_strobe", 64'(dri_ctrl), 64'h403);
    chk("rmw_wr_data", 64'(dri_wdata), 64'h0_FFFF_000F);
    tick;
    dri_rdata = {1'b1, 32'h0};
    tick;
    dri_rdata = '0;
    chk("rmw_rdata", 64'(rsp_rdata), 64'hFFFF_0000);
    chk("rmw_err", 64'(rsp_err), 64'd0);
    handshake("rmw");
    // read timeout: response exactly 8 cycles after wait begins
    issue(2'b00, 9'h055, 32'h0, 32'h0);
    tick;
    for (int i = 0; i < 7; i++) tick;
    chk("to_not_yet", 64'(rsp_valid), 64'd0);
    tick;
    chk("to_valid", 64'(rsp_valid), 64'd1);
    chk("to_err", 64'(rsp_err), 64'd1);
    handshake("to");
    // RMW read timeout: no write strobe
    saw_wr = 1'b0;
    issue(2'b10, 9'h003, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 12; i++) begin
      tick;
      if (dri_ctrl[10:9] == 2'b10) saw_wr = 1'b1;
    end
    chk("rmw_to_valid", 64'(rsp_valid), 64'd1);
    chk("rmw_to_err", 64'(rsp_err), 64'd1);
    chk("rmw_to_no_write", 64'(saw_wr), 64'd0);
    handshake("rmw_to");
    // ack on the terminal wait cycle still succeeds
    issue(2'b00, 9'h0AA, 32'h0, 32'h0);
    tick;
    for (int i = 0; i < 7; i++) tick;
    dri_rdata = {1'b1, 32'h0BAD_F00D};
    tick;
    dri_rdata = '0;
    chk("edge_ack_valid", 64'(rsp_valid), 64'd1);
    chk("edge_ack_err", 64'(rsp_err), 64'd0);
    chk("edge_ack_rdata", 64'(rsp_rdata), 64'h0BAD_F00D);
    handshake("edge");
    // reserved op: immediate error, response stable under backpressure
    issue(2'b11, 9'h1FF, 32'h1111_1111, 32'h0);
    chk("rsv_ctrl", 64'(dri_ctrl), 64'h0);
    chk("rsv_err", 64'(rsp_err), 64'd1);
    chk("rsv_rdata", 64'(rsp_rdata), 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rsv_hold", {30'd0, rsp_valid, rsp_err, rsp_rdata}, {30'd0, 1'b1, 1'b1, 32'h0});
      chk("rsv_hold_ctrl", 64'(dri_ctrl), 64'h0);
    end
    handshake("rsv");
    // reset during RD_WAIT
    issue(2'b00, 9'h021, 32'h0, 32'h0);
    dri_interrupt = 1'b1;
    tick;
    dri_interrupt = 1'b0;
    chk("mid_irq_set", 64'(irq_pending), 64'd1);
    chk("mid_busy", 64'(busy), 64'd1);
    RESETN = 1'b0;
    tick;
    chk_reset("mid");
    RESETN = 1'b1;
    tick;
    chk("mid_ready_back", 64'(cmd_ready), 64'd1);
    // interrupt flag
    dri_interrupt = 1'b1;
    tick;
    dri_interrupt = 1'b0;
    chk("irq_set", 64'(irq_pending), 64'd1);
    tick;
    chk("irq_sticky", 64'(irq_pending), 64'd1);
    irq_clr = 1'b1;
    tick;
    chk("irq_clr", 64'(irq_pending), 64'd0);
    dri_interrupt = 1'b1;
    tick;
    dri_interrupt = 1'b0;
    irq_clr = 1'b0;
    chk("irq_set_wins", 64'(irq_pending), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
